// File: rtl/qr_tx_pkg.sv
// Shared types and constants for the quarter-rate TX mux path.
// The word-complement helper is kept here so the sequencer and any future TX blocks agree on it.
package qr_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_DATA
    } qr_seq_state_t;

    typedef logic [3:0] qr_word_t;

    localparam logic [1:0] PH_LAST = 2'd3;

    // The analog mux inverts, so pre-complementing makes the serial line carry true data.
    function automatic qr_word_t cmp_word(input qr_word_t w, input logic inv);
        return inv ? ~w : w;
    endfunction

endpackage

// File: rtl/qr_word_fifo2.sv
// Two-entry word FIFO between the TX framing logic and the mux sequencer.
// Pushes while full and pops while empty are ignored.
module qr_word_fifo2
    import qr_tx_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  qr_word_t wdata,
    output logic     full,
    output logic     empty,
    output qr_word_t head
);

    qr_word_t   mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/qr_mux_sequencer.sv
// Sequencer for the quarter-rate 4:1 inverting mux: buffers words, holds each one for a
// 4-phase frame on DIN0..DIN3, drives the phase selects and inserts idle/training words.
module qr_mux_sequencer
    import qr_tx_pkg::*;
#(
    parameter logic     INV_COMP   = 1'b1,
    parameter qr_word_t IDLE_WORD  = 4'h0,
    parameter qr_word_t TRAIN_WORD = 4'h5,
    parameter int       TRAIN_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       train_req,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       DIN0,
    output logic       DIN1,
    output logic       DIN2,
    output logic       DIN3,
    output logic       E0,
    output logic       E1,
    output logic       train_done,
    output logic       underflow,
    output logic [7:0] uflow_cnt
);

    localparam qr_word_t   IDLE_DRV   = cmp_word(IDLE_WORD, INV_COMP);
    localparam qr_word_t   TRAIN_DRV  = cmp_word(TRAIN_WORD, INV_COMP);
    localparam logic [7:0] LAST_FRAME = 8'(TRAIN_LEN - 1);

    qr_seq_state_t state;
    logic [1:0]    ph;
    qr_word_t      din;
    logic [7:0]    frame_cnt;
    logic          stop_pend;
    logic          train_pend;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    qr_word_t      fifo_head;

    logic          running;
    logic          boundary;
    logic          stopping;
    logic          last_frame;

    assign in_ready   = !fifo_full && !rst;
    assign fifo_push  = in_valid && in_ready;
    assign running    = (state != ST_IDLE);
    assign boundary   = running && (ph == PH_LAST);
    // An en drop anywhere in the frame, including on the boundary cycle itself, ends the run.
    assign stopping   = stop_pend || !en;
    assign last_frame = (frame_cnt == LAST_FRAME);
    assign fifo_pop   = boundary && (state == ST_DATA) && !stopping && !fifo_empty;

    assign {DIN3, DIN2, DIN1, DIN0} = din;
    assign E0 = ph[0];
    assign E1 = ph[1];

    qr_word_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ph         <= 2'd0;
            din        <= IDLE_DRV;
            frame_cnt  <= 8'd0;
            stop_pend  <= 1'b0;
            train_pend <= 1'b0;
            train_done <= 1'b0;
            underflow  <= 1'b0;
            uflow_cnt  <= 8'd0;
        end else begin
            train_done <= 1'b0;
            underflow  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ph         <= 2'd0;
                    frame_cnt  <= 8'd0;
                    stop_pend  <= 1'b0;
                    train_pend <= 1'b0;
                    if (en) begin
                        state <= train_req ? ST_TRAIN : ST_DATA;
                    end
                end
                ST_TRAIN, ST_DATA: begin
                    ph <= ph + 2'd1;
                    if (!en) begin
                        stop_pend <= 1'b1;
                    end
                    if ((state == ST_DATA) && train_req) begin
                        train_pend <= 1'b1;
                    end
                    // Raised one cycle early so the registered pulse lines up with the last boundary.
                    if ((state == ST_TRAIN) && (ph == 2'd2) && last_frame && en && !stop_pend) begin
                        train_done <= 1'b1;
                    end
                    if (boundary) begin
                        if (stopping) begin
                            din        <= IDLE_DRV;
                            state      <= ST_IDLE;
                            frame_cnt  <= 8'd0;
                            stop_pend  <= 1'b0;
                            train_pend <= 1'b0;
                        end else if (state == ST_TRAIN) begin
                            din <= TRAIN_DRV;
                            if (last_frame) begin
                                frame_cnt <= 8'd0;
                                state     <= ST_DATA;
                            end else begin
                                frame_cnt <= frame_cnt + 8'd1;
                            end
                        end else begin
                            if (!fifo_empty) begin
                                din <= cmp_word(fifo_head, INV_COMP);
                            end else begin
                                din       <= IDLE_DRV;
                                underflow <= 1'b1;
                                if (uflow_cnt != 8'hFF) begin
                                    uflow_cnt <= uflow_cnt + 8'd1;
                                end
                            end
                            if (train_pend || train_req) begin
                                state      <= ST_TRAIN;
                                train_pend <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ph    <= 2'd0;
                end
            endcase
        end
    end

endmodule
